// File: rtl/cfg_info_responder.sv
`default_nettype none
// ============================================================================
// Module   : cfg_info_responder
// Brief    : Read-mostly responder exposing the core's static configuration
//            (features, halt/exception addresses, region tables) over a
//            valid/ready bus, plus a query FSM that classifies a programmed
//            address against every region rule, one rule per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_info_responder #(
    parameter logic [63:0]       FeatureWord      = 64'h0,
    parameter logic [63:0]       HaltAddress      = 64'h800,
    parameter logic [63:0]       ExceptionAddress = 64'h808,
    parameter int                NrExecRules      = 3,
    parameter int                NrNonIdemRules   = 2,
    parameter int                NrCachedRules    = 1,
    parameter logic [15:0][63:0] ExecBase         = '0,
    parameter logic [15:0][63:0] ExecLen          = '0,
    parameter logic [15:0][63:0] NonIdemBase      = '0,
    parameter logic [15:0][63:0] NonIdemLen       = '0,
    parameter logic [15:0][63:0] CachedBase       = '0,
    parameter logic [15:0][63:0] CachedLen        = '0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [11:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    // Table populations in the widths used by the decode and scan compares
    localparam logic [4:0] c_NR_EXEC   = 5'(NrExecRules);
    localparam logic [4:0] c_NR_NONIDEM = 5'(NrNonIdemRules);
    localparam logic [4:0] c_NR_CACHED = 5'(NrCachedRules);
    localparam logic [5:0] c_EXEC_END  = 6'(NrExecRules);
    localparam logic [5:0] c_NI_END    = 6'(NrExecRules + NrNonIdemRules);
    localparam logic [5:0] c_N_TOTAL   = 6'(NrExecRules + NrNonIdemRules + NrCachedRules);
    localparam logic [5:0] c_LAST_RULE = c_N_TOTAL - 6'd1;
    localparam logic [63:0] c_COUNTS   = {40'h0, 8'(NrCachedRules), 8'(NrNonIdemRules), 8'(NrExecRules)};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rsp_valid;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [63:0] r_query_addr;
    logic [5:0]  r_idx;
    logic [2:0]  r_result;

    logic [63:0] w_rdata;
    logic        w_err;
    logic        w_is_query;
    logic [3:0]  w_sub;
    logic [63:0] w_rule_base;
    logic [63:0] w_rule_len;
    logic [2:0]  w_rule_cat;
    logic [64:0] w_rule_end;
    logic        w_match;
    logic [2:0]  w_next_result;

    // Ready only while idle and out of reset
    assign req_ready_o = (r_state == S_IDLE) && !rst_i;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

    // Register-map decode of the incoming request
    always_comb begin
        w_rdata    = '0;
        w_err      = 1'b0;
        w_is_query = 1'b0;
        if (req_addr_i[2:0] != 3'b000) begin
            w_err = 1'b1;
        end else if (req_we_i) begin
            w_err = (req_addr_i != 12'h080);
        end else begin
            case (req_addr_i[11:8])
                4'h0: begin
                    case (req_addr_i[7:0])
                        8'h00:   w_rdata = FeatureWord;
                        8'h08:   w_rdata = HaltAddress;
                        8'h10:   w_rdata = ExceptionAddress;
                        8'h18:   w_rdata = c_COUNTS;
                        8'h80:   w_rdata = r_query_addr;
                        8'h88:   w_is_query = 1'b1;
                        default: w_err = 1'b1;
                    endcase
                end
                4'h1: begin
                    if ({1'b0, req_addr_i[7:4]} < c_NR_EXEC)
                        w_rdata = req_addr_i[3] ? ExecLen[req_addr_i[7:4]] : ExecBase[req_addr_i[7:4]];
                end
                4'h2: begin
                    if ({1'b0, req_addr_i[7:4]} < c_NR_NONIDEM)
                        w_rdata = req_addr_i[3] ? NonIdemLen[req_addr_i[7:4]] : NonIdemBase[req_addr_i[7:4]];
                end
                4'h3: begin
                    if ({1'b0, req_addr_i[7:4]} < c_NR_CACHED)
                        w_rdata = req_addr_i[3] ? CachedLen[req_addr_i[7:4]] : CachedBase[req_addr_i[7:4]];
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    // Select the rule under scan: exec first, then non-idempotent, then cached
    always_comb begin
        w_sub       = '0;
        w_rule_base = '0;
        w_rule_len  = '0;
        w_rule_cat  = 3'b000;
        if (r_idx < c_EXEC_END) begin
            w_sub       = 4'(r_idx);
            w_rule_base = ExecBase[w_sub];
            w_rule_len  = ExecLen[w_sub];
            w_rule_cat  = 3'b001;
        end else if (r_idx < c_NI_END) begin
            w_sub       = 4'(r_idx - c_EXEC_END);
            w_rule_base = NonIdemBase[w_sub];
            w_rule_len  = NonIdemLen[w_sub];
            w_rule_cat  = 3'b010;
        end else begin
            w_sub       = 4'(r_idx - c_NI_END);
            w_rule_base = CachedBase[w_sub];
            w_rule_len  = CachedLen[w_sub];
            w_rule_cat  = 3'b100;
        end
    end

    // End address kept at 65 bits so regions touching the top never wrap
    assign w_rule_end    = {1'b0, w_rule_base} + {1'b0, w_rule_len};
    assign w_match       = (r_query_addr >= w_rule_base) && ({1'b0, r_query_addr} < w_rule_end);
    assign w_next_result = r_result | (w_match ? w_rule_cat : 3'b000);

    // Transaction FSM: accept, optionally scan, then hold the response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_query_addr <= '0;
            r_idx        <= '0;
            r_result     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (w_is_query && (c_N_TOTAL != 6'd0)) begin
                            r_state  <= S_SCAN;
                            r_idx    <= '0;
                            r_result <= '0;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rdata;
                            r_rsp_err   <= w_err;
                            if (req_we_i && !w_err)
                                r_query_addr <= req_wdata_i;
                        end
                    end
                end
                S_SCAN: begin
                    r_result <= w_next_result;
                    r_idx    <= r_idx + 6'd1;
                    if (r_idx == c_LAST_RULE) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= {61'h0, w_next_result};
                        r_rsp_err   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_info_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_info_responder
// Brief    : Self-checking bench for cfg_info_responder. Two instances: one
//            with the default region tables, one with a rule reaching the top
//            of the address space. Directed cases followed by random traffic,
//            all checked against a table-driven reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_info_responder;

    localparam logic [63:0] c_FEAT_A = 64'h2A5;
    localparam logic [15:0][63:0] c_A_EXEC_BASE = {{12{64'h0}}, 64'hDEAD_BEEF, 64'h0, 64'h1_0000, 64'h8000_0000};
    localparam logic [15:0][63:0] c_A_EXEC_LEN  = {{12{64'h0}}, 64'h100, 64'h1000, 64'h1_0000, 64'h4000_0000};
    localparam logic [15:0][63:0] c_A_NI_BASE   = {{14{64'h0}}, 64'h1000, 64'h8000_1000};
    localparam logic [15:0][63:0] c_A_CA_BASE   = {{15{64'h0}}, 64'h8000_0000};
    localparam logic [15:0][63:0] c_A_CA_LEN    = {{15{64'h0}}, 64'h4000_0000};
    localparam logic [15:0][63:0] c_B_EXEC_BASE = {{15{64'h0}}, 64'hFFFF_FFFF_FFFF_F000};
    localparam logic [15:0][63:0] c_B_EXEC_LEN  = {{15{64'h0}}, 64'h2000};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][11:0] req_addr = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][63:0] req_wdata = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [1:0][63:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: tables, populations, static values, query address
    logic [63:0] m_base [2][3][16];
    logic [63:0] m_len  [2][3][16];
    int          m_nr   [2][3];
    logic [63:0] m_feat [2];
    logic [63:0] m_q    [2];

    always #5 clk = ~clk;

    cfg_info_responder #(
        .FeatureWord(c_FEAT_A), .HaltAddress(64'h800), .ExceptionAddress(64'h808),
        .NrExecRules(3), .NrNonIdemRules(2), .NrCachedRules(1),
        .ExecBase(c_A_EXEC_BASE), .ExecLen(c_A_EXEC_LEN),
        .NonIdemBase(c_A_NI_BASE), .NonIdemLen('0),
        .CachedBase(c_A_CA_BASE), .CachedLen(c_A_CA_LEN)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_we_i(req_we[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    cfg_info_responder #(
        .FeatureWord(64'h0), .HaltAddress(64'h800), .ExceptionAddress(64'h808),
        .NrExecRules(1), .NrNonIdemRules(0), .NrCachedRules(0),
        .ExecBase(c_B_EXEC_BASE), .ExecLen(c_B_EXEC_LEN),
        .NonIdemBase('0), .NonIdemLen('0), .CachedBase('0), .CachedLen('0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_we_i(req_we[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected response and latency (accept edge to first valid cycle)
    function automatic void model(input int w, input logic [11:0] addr, input logic we,
                                  input logic [63:0] wdata, output logic [63:0] rd,
                                  output logic er, output int lat);
        int tbl, idx, total;
        logic [64:0] lim;
        rd = '0; er = 1'b0; lat = 1;
        total = m_nr[w][0] + m_nr[w][1] + m_nr[w][2];
        if (addr % 8 != 0) er = 1'b1;
        else if (we) begin
            if (addr == 12'h080) m_q[w] = wdata;
            else er = 1'b1;
        end
        else if (addr == 12'h000) rd = m_feat[w];
        else if (addr == 12'h008) rd = 64'h800;
        else if (addr == 12'h010) rd = 64'h808;
        else if (addr == 12'h018) rd = 64'(m_nr[w][0] + m_nr[w][1] * 256 + m_nr[w][2] * 65536);
        else if (addr == 12'h080) rd = m_q[w];
        else if (addr == 12'h088) begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < m_nr[w][c]; i++) begin
                    lim = 65'(m_base[w][c][i]) + 65'(m_len[w][c][i]);
                    if (m_q[w] >= m_base[w][c][i] && 65'(m_q[w]) < lim) rd[c] = 1'b1;
                end
            if (total > 0) lat = total + 1;
        end
        else if (addr >= 12'h100 && addr < 12'h400) begin
            tbl = int'(addr) / 256 - 1;
            idx = (int'(addr) % 256) / 16;
            if (idx < m_nr[w][tbl])
                rd = (addr % 16 == 8) ? m_len[w][tbl][idx] : m_base[w][tbl][idx];
        end
        else er = 1'b1;
    endfunction

    // One full transaction on instance w, holding off the response for 'hold' cycles
    task automatic txn(input int w, input logic [11:0] addr, input logic we,
                       input logic [63:0] wdata, input int hold);
        logic [63:0] erd;
        logic        eer;
        int          elat, lat, guard;
        model(w, addr, we, wdata, erd, eer, elat);
        req_addr[w] = addr; req_we[w] = we; req_wdata[w] = wdata; req_valid[w] = 1'b1;
        guard = 0;
        while (req_ready[w] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        check_eq("req_ready_idle", 64'(req_ready[w]), 64'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid[w] = 1'b0;
        lat = 1;
        while (rsp_valid[w] !== 1'b1 && lat < 64) begin
            check_eq("req_ready_busy", 64'(req_ready[w]), 64'h0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(elat));
        check_eq("rdata", rsp_rdata[w], erd);
        check_eq("err", 64'(rsp_err[w]), 64'(eer));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(rsp_valid[w]), 64'h1);
            check_eq("hold_rdata", rsp_rdata[w], erd);
            check_eq("hold_err", 64'(rsp_err[w]), 64'(eer));
            check_eq("hold_ready", 64'(req_ready[w]), 64'h0);
        end
        rsp_ready[w] = 1'b1;
        @(negedge clk);
        rsp_ready[w] = 1'b0;
        check_eq("ready_after_rsp", 64'(req_ready[w]), 64'h1);
        check_eq("valid_after_rsp", 64'(rsp_valid[w]), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pts [2][10];
        logic [63:0] v;
        logic [11:0] a;
        int          w, sel;

        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 16; k++) begin
                    m_base[i][c][k] = '0;
                    m_len[i][c][k]  = '0;
                end
        m_base[0][0][0] = 64'h8000_0000; m_len[0][0][0] = 64'h4000_0000;
        m_base[0][0][1] = 64'h1_0000;    m_len[0][0][1] = 64'h1_0000;
        m_base[0][0][2] = 64'h0;         m_len[0][0][2] = 64'h1000;
        m_base[0][0][3] = 64'hDEAD_BEEF; m_len[0][0][3] = 64'h100;
        m_base[0][1][0] = 64'h8000_1000;
        m_base[0][1][1] = 64'h1000;
        m_base[0][2][0] = 64'h8000_0000; m_len[0][2][0] = 64'h4000_0000;
        m_base[1][0][0] = 64'hFFFF_FFFF_FFFF_F000; m_len[1][0][0] = 64'h2000;
        m_nr[0][0] = 3; m_nr[0][1] = 2; m_nr[0][2] = 1;
        m_nr[1][0] = 1; m_nr[1][1] = 0; m_nr[1][2] = 0;
        m_feat[0] = c_FEAT_A; m_feat[1] = 64'h0;
        m_q[0] = '0; m_q[1] = '0;

        pts[0] = '{64'h8000_0000, 64'hBFFF_FFF8, 64'hC000_0000, 64'h7FFF_FFF8, 64'h1_0000,
                   64'h1_FFF8, 64'h2_0000, 64'h0, 64'hFF8, 64'h1000};
        pts[1] = '{64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_EFF8, 64'hFFFF_FFFF_FFFF_FFF8,
                   64'hFFFF_FFFF_FFFF_F800, 64'h0, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF0,
                   64'h7FFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_F008, 64'h1000};

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ready", 64'(req_ready[0]), 64'h0);
            check_eq("rst_valid", 64'(rsp_valid[0]), 64'h0);
            check_eq("rst_rdata", rsp_rdata[0], 64'h0);
            check_eq("rst_err", 64'(rsp_err[0]), 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_post_rst", 64'(req_ready[0]), 64'h1);

        // Directed queries and boundaries
        txn(0, 12'h080, 1'b1, 64'h8000_1000, 0);
        txn(0, 12'h088, 1'b0, 64'h0, 0);
        txn(0, 12'h080, 1'b1, 64'hC000_0000, 0);
        txn(0, 12'h088, 1'b0, 64'h0, 0);
        txn(0, 12'h080, 1'b1, 64'h0FFF, 0);
        txn(0, 12'h088, 1'b0, 64'h0, 0);
        txn(0, 12'h080, 1'b1, 64'h1000, 0);
        txn(0, 12'h088, 1'b0, 64'h0, 1);
        txn(1, 12'h080, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        txn(1, 12'h088, 1'b0, 64'h0, 0);

        // Static, table and error accesses
        txn(0, 12'h008, 1'b0, 64'h0, 0);
        txn(0, 12'h018, 1'b0, 64'h0, 0);
        txn(0, 12'h130, 1'b0, 64'h0, 0);
        txn(0, 12'h004, 1'b0, 64'h0, 0);
        txn(0, 12'h000, 1'b1, 64'hFFFF, 0);
        txn(0, 12'h000, 1'b0, 64'h0, 0);
        txn(0, 12'h010, 1'b0, 64'h0, 3);

        // Reset in the second scan cycle aborts the query
        txn(0, 12'h080, 1'b1, 64'h1_0000, 0);
        req_addr[0] = 12'h088; req_we[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check_eq("scan_no_valid", 64'(rsp_valid[0]), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("abort_valid", 64'(rsp_valid[0]), 64'h0);
            check_eq("abort_ready", 64'(req_ready[0]), 64'h0);
        end
        rst = 1'b0;
        m_q[0] = '0; m_q[1] = '0;
        @(negedge clk);
        check_eq("abort_ready_after", 64'(req_ready[0]), 64'h1);
        check_eq("abort_valid_after", 64'(rsp_valid[0]), 64'h0);
        txn(0, 12'h080, 1'b0, 64'h0, 0);
        txn(0, 12'h088, 1'b0, 64'h0, 0);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            w   = ($urandom_range(0, 9) < 7) ? 0 : 1;
            sel = $urandom_range(0, 9);
            v   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : pts[w][$urandom_range(0, 9)];
            case (sel)
                0, 1: txn(w, 12'h080, 1'b1, v, $urandom_range(0, 2));
                2, 3: txn(w, 12'h088, 1'b0, 64'h0, $urandom_range(0, 3));
                4: begin
                    a = 12'($urandom_range(0, 4) * 8);
                    if (a == 12'h020) a = 12'h080;
                    txn(w, a, 1'b0, 64'h0, $urandom_range(0, 2));
                end
                5, 6: begin
                    a = 12'(256 * $urandom_range(1, 3) + 16 * $urandom_range(0, 4) + 8 * $urandom_range(0, 1));
                    txn(w, a, 1'b0, 64'h0, $urandom_range(0, 2));
                end
                7: begin
                    a = {9'($urandom), 3'($urandom_range(1, 7))};
                    txn(w, a, $urandom_range(0, 1) == 1, v, 0);
                end
                8: begin
                    a = {9'($urandom), 3'b000};
                    txn(w, a, 1'b1, v, $urandom_range(0, 1));
                end
                default: txn(w, 12'($urandom), 1'b0, 64'h0, $urandom_range(0, 1));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
